load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 clk  in  1  system clock; all state updates on rising edge.
REQ-002 resetn  in  1  reset; one clock; reset is asynchronous and active-low.
REQ-003 start  in  1  access request; sampled only in IDLE.
REQ-004 op  in  6  MIPS opcode: lb 100000, lh 100001, lwl 100010, lw 100011, lbu 100100, lhu 100101, lwr 100110, sb 101000, sh 101001, swl 101010, sw 101011, swr 101110.
REQ-005 addr  in  32  effective byte address.
REQ-006 rt_val  in  32  rt register value: store data, or merge source for lwl/lwr.
REQ-007 busy  out  1  high whenever state is not IDLE.
REQ-008 done  out  1  one-cycle completion pulse.
REQ-009 mem_req  out  1  memory request; held high until acknowledged.
REQ-010 mem_we  out  1  write enable, valid while mem_req=1.
REQ-011 mem_addr  out  32  {addr[31:2],2'b00}.
REQ-012 mem_wstrb  out  4  byte enables; bit i = byte lane [8i+7:8i].
REQ-013 mem_wdata  out  32  lane-aligned store data.
REQ-014 mem_ack  in  1  memory acknowledge; sampled only while mem_req=1.
REQ-015 mem_rdata  in  32  read word, valid in the mem_ack cycle.
REQ-016 ld_word / ld_rt / ld_op / ld_ea  out  32/32/6/2  registered raw word, rt_val, op, addr[1:0] for the downstream load-alignment stage.
REQ-017 adel / ades  out  1/1  load / store address error, valid while done=1.

Function
REQ-018 FSM states IDLE, ACCESS, DONE; IDLE->ACCESS on start with legal aligned memory op; IDLE->DONE on start with misaligned or non-memory op; ACCESS->DONE on mem_ack=1; DONE->IDLE unconditionally.
REQ-019 On accepted start: op, addr, rt_val latched; all mem_* outputs driven from latched values and stable for the whole ACCESS state.
REQ-020 mem_req=1 exactly in ACCESS; done=1 exactly in DONE; minimum latency start edge to done = 2 cycles (ack in first ACCESS cycle).
REQ-021 start while busy=1 ignored; no queueing.
REQ-022 Loads: mem_we=0, mem_wstrb=0000; mem_rdata captured into ld_word on ack edge.
REQ-023 ld_op, ld_ea, ld_rt updated on every accepted start; ld_word updated only on load ack; all ld_* held until next update.
REQ-024 sw: strb 1111, wdata=rt. sh: strb ea[1]?1100:0011, wdata {2{rt[15:0]}}. sb: strb=0001<<ea, wdata {4{rt[7:0]}}.
REQ-025 swl by ea 00/01/10/11: strb 0001/0011/0111/1111; wdata {24'b0,rt[31:24]} / {16'b0,rt[31:16]} / {8'b0,rt[31:8]} / rt.
REQ-026 swr by ea 00/01/10/11: strb 1111/1110/1100/1000; wdata rt / {rt[23:0],8'b0} / {rt[15:0],16'b0} / {rt[7:0],24'b0}.
REQ-027 Misaligned: lw/sw with ea!=00, lh/lhu/sh with ea[0]=1 -> no mem_req; done next cycle with adel (loads) or ades (stores) =1.
REQ-028 lb/lbu/lwl/lwr/sb/swl/swr never misaligned.
REQ-029 Non-memory op on start: no mem_req; done next cycle with adel=ades=0.
REQ-030 adel/ades cleared on next accepted start; hold otherwise.
REQ-031 mem_ack while mem_req=0: ignored.

Reset
REQ-032 resetn=0 immediately forces: state IDLE; busy, done, mem_req, mem_we, adel, ades =0; mem_wstrb=0000; mem_addr, mem_wdata, ld_word, ld_rt =0; ld_op=000000; ld_ea=00.
REQ-033 Reset during ACCESS aborts the access: mem_req drops asynchronously; no done pulse follows reset release.
REQ-034 First start after reset release accepted normally.

Verification
REQ-035 lw addr=0x100, mem_rdata=0xDEADBEEF, ack after 3 wait cycles -> mem_req high 4 cycles, mem_addr=0x100, then done=1, ld_word=0xDEADBEEF, ld_ea=00, adel=0.
REQ-036 sb addr=0x203, rt=0x000000A5, immediate ack -> mem_we=1, strb=1000, wdata=0xA5A5A5A5, mem_addr=0x200; done 2 cycles after start.
REQ-037 swl addr=0x301, rt=0x11223344 -> strb=0011, wdata=0x00001122; swr addr=0x302 -> strb=1100, wdata=0x33440000.
REQ-038 lh addr=0x401 -> no mem_req, done next cycle, adel=1; sw addr=0x402 -> ades=1.
REQ-039 start pulsed during ACCESS -> ignored, ld_op unchanged; resetn low mid-ACCESS -> mem_req=0 at once, no done after release.
REQ-040 lwr addr=0x505, rt=0xCAFEBABE, rdata=0x01020304 -> ld_ea=01, ld_rt=0xCAFEBABE, ld_word=0x01020304, ld_op=100110.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: decodes MIPS memory ops, aligns store data and byte enables, runs a
// single-outstanding memory handshake and registers the raw load word for the alignment stage.
module load_store_unit (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [5:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic        done,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] ld_word,
  output logic [31:0] ld_rt,
  output logic [5:0]  ld_op,
  output logic [1:0]  ld_ea,
  output logic        adel,
  output logic        ades
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t      state_reg, state_next;
  logic        mem_we_reg;
  logic [31:0] mem_addr_reg;
  logic [3:0]  mem_wstrb_reg;
  logic [31:0] mem_wdata_reg;
  logic [31:0] ld_word_reg;
  logic [31:0] ld_rt_reg;
  logic [5:0]  ld_op_reg;
  logic [1:0]  ld_ea_reg;
  logic        adel_reg;
  logic        ades_reg;

  logic        is_load, is_store, misalign;
  logic [3:0]  wstrb_next;
  logic [31:0] wdata_next;
  logic [1:0]  ea;
  logic        accept, go_mem;

  assign ea = addr[1:0];

  // Decode of the incoming request; only meaningful in the cycle it is accepted.
  always_comb begin
    is_load    = 1'b0;
    is_store   = 1'b0;
    misalign   = 1'b0;
    wstrb_next = 4'b0000;
    wdata_next = 32'h0;
    case (op)
      6'b100000, 6'b100100, 6'b100010, 6'b100110: is_load = 1'b1;
      6'b100001, 6'b100101: begin
        is_load  = 1'b1;
        misalign = ea[0];
      end
      6'b100011: begin
        is_load  = 1'b1;
        misalign = (ea != 2'b00);
      end
      6'b101000: begin
        is_store   = 1'b1;
        wstrb_next = 4'b0001 << ea;
        wdata_next = {4{rt_val[7:0]}};
      end
      6'b101001: begin
        is_store   = 1'b1;
        misalign   = ea[0];
        wstrb_next = ea[1] ? 4'b1100 : 4'b0011;
        wdata_next = {2{rt_val[15:0]}};
      end
      6'b101010: begin
        is_store = 1'b1;
        case (ea)
          2'b00:   begin wstrb_next = 4'b0001; wdata_next = {24'h0, rt_val[31:24]}; end
          2'b01:   begin wstrb_next = 4'b0011; wdata_next = {16'h0, rt_val[31:16]}; end
          2'b10:   begin wstrb_next = 4'b0111; wdata_next = {8'h0, rt_val[31:8]}; end
          default: begin wstrb_next = 4'b1111; wdata_next = rt_val; end
        endcase
      end
      6'b101011: begin
        is_store   = 1'b1;
        misalign   = (ea != 2'b00);
        wstrb_next = 4'b1111;
        wdata_next = rt_val;
      end
      6'b101110: begin
        is_store = 1'b1;
        case (ea)
          2'b00:   begin wstrb_next = 4'b1111; wdata_next = rt_val; end
          2'b01:   begin wstrb_next = 4'b1110; wdata_next = {rt_val[23:0], 8'h0}; end
          2'b10:   begin wstrb_next = 4'b1100; wdata_next = {rt_val[15:0], 16'h0}; end
          default: begin wstrb_next = 4'b1000; wdata_next = {rt_val[7:0], 24'h0}; end
        endcase
      end
      default: ;
    endcase
  end

  assign accept = (state_reg == IDLE) && start;
  assign go_mem = (is_load || is_store) && !misalign;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = go_mem ? ACCESS : DONE;
      ACCESS:  if (mem_ack) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg     <= IDLE;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= 32'h0;
      mem_wstrb_reg <= 4'b0000;
      mem_wdata_reg <= 32'h0;
      ld_word_reg   <= 32'h0;
      ld_rt_reg     <= 32'h0;
      ld_op_reg     <= 6'b000000;
      ld_ea_reg     <= 2'b00;
      adel_reg      <= 1'b0;
      ades_reg      <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        ld_op_reg     <= op;
        ld_ea_reg     <= ea;
        ld_rt_reg     <= rt_val;
        mem_addr_reg  <= {addr[31:2], 2'b00};
        mem_we_reg    <= go_mem && is_store;
        mem_wstrb_reg <= (go_mem && is_store) ? wstrb_next : 4'b0000;
        mem_wdata_reg <= (go_mem && is_store) ? wdata_next : 32'h0;
        adel_reg      <= is_load && misalign;
        ades_reg      <= is_store && misalign;
      end
      // Raw word is captured only for loads; stores leave the previous load word intact.
      if (state_reg == ACCESS && mem_ack && !mem_we_reg)
        ld_word_reg <= mem_rdata;
    end
  end

  assign busy      = (state_reg != IDLE);
  assign done      = (state_reg == DONE);
  assign mem_req   = (state_reg == ACCESS);
  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wstrb = mem_wstrb_reg;
  assign mem_wdata = mem_wdata_reg;
  assign ld_word   = ld_word_reg;
  assign ld_rt     = ld_rt_reg;
  assign ld_op     = ld_op_reg;
  assign ld_ea     = ld_ea_reg;
  assign adel      = adel_reg;
  assign ades      = ades_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: hand-computed expectations checked with immediate assertions.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        start = 1'b0;
  logic [5:0]  op = 6'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] rt_val = 32'h0;
  logic        busy, done, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic [31:0] ld_word, ld_rt;
  logic [5:0]  ld_op;
  logic [1:0]  ld_ea;
  logic        adel, ades;

  int nvec = 0;
  int nerr = 0;

  load_store_unit dut (
    .clk(clk), .resetn(resetn), .start(start), .op(op), .addr(addr), .rt_val(rt_val),
    .busy(busy), .done(done), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .ld_word(ld_word), .ld_rt(ld_rt), .ld_op(ld_op), .ld_ea(ld_ea), .adel(adel), .ades(ades)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [5:0] o, input logic [31:0] a, input logic [31:0] r);
    start = 1'b1; op = o; addr = a; rt_val = r;
    tick();
    start = 1'b0;
  endtask

  // Store with immediate ack: checks lane data in ACCESS and the done pulse two cycles after start.
  task automatic do_store(input string tag, input logic [5:0] o, input logic [31:0] a,
                          input logic [31:0] r, input logic [3:0] strb, input logic [31:0] wd);
    issue(o, a, r);
    check({tag, "_req"}, mem_req, 1);
    check({tag, "_we"}, mem_we, 1);
    check({tag, "_strb"}, mem_wstrb, strb);
    check({tag, "_wdata"}, mem_wdata, wd);
    check({tag, "_addr"}, mem_addr, {a[31:2], 2'b00});
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check({tag, "_done"}, done, 1);
    check({tag, "_ades"}, ades, 0);
    tick();
    $display("store %s op=%b addr=%h rt=%h strb=%b wdata=%h", tag, o, a, r, strb, wd);
  endtask

  initial begin
    #2 resetn = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_req", mem_req, 0);
    check("rst_strb", mem_wstrb, 0);
    check("rst_ldop", ld_op, 0);
    check("rst_ldword", ld_word, 0);
    tick(); tick();
    resetn = 1'b1;
    tick();
    $display("reset released");

    // ack while idle must not move the FSM
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("idle_ack_busy", busy, 0);
    check("idle_ack_done", done, 0);
    $display("idle ack ignored");

    // lw with three wait cycles
    issue(6'b100011, 32'h100, 32'h0);
    for (int i = 0; i < 4; i++) begin
      check("lw_req", mem_req, 1);
      check("lw_addr", mem_addr, 32'h100);
      check("lw_done_low", done, 0);
      if (i == 3) begin
        mem_ack = 1'b1;
        mem_rdata = 32'hDEADBEEF;
      end
      tick();
    end
    mem_ack = 1'b0;
    mem_rdata = 32'h0;
    check("lw_we", mem_we, 0);
    check("lw_done", done, 1);
    check("lw_req_off", mem_req, 0);
    check("lw_word", ld_word, 32'hDEADBEEF);
    check("lw_ea", ld_ea, 2'b00);
    check("lw_adel", adel, 0);
    tick();
    check("lw_idle", busy, 0);
    $display("load lw addr=00000100 word=%h", ld_word);

    do_store("sb", 6'b101000, 32'h203, 32'h000000A5, 4'b1000, 32'hA5A5A5A5);
    check("sb_keep_word", ld_word, 32'hDEADBEEF);
    do_store("swl", 6'b101010, 32'h301, 32'h11223344, 4'b0011, 32'h00001122);
    do_store("swr", 6'b101110, 32'h302, 32'h11223344, 4'b1100, 32'h33440000);
    do_store("sh", 6'b101001, 32'h402 - 32'h0, 32'h0000BEEF, 4'b1100, 32'hBEEFBEEF);

    // misaligned lh
    issue(6'b100001, 32'h401, 32'h0);
    check("lh_req", mem_req, 0);
    check("lh_done", done, 1);
    check("lh_adel", adel, 1);
    check("lh_ades", ades, 0);
    tick();
    $display("misaligned lh addr=00000401 adel=%b", adel);

    // misaligned sw clears adel
    issue(6'b101011, 32'h402, 32'h12345678);
    check("sw_req", mem_req, 0);
    check("sw_done", done, 1);
    check("sw_ades", ades, 1);
    check("sw_adel", adel, 0);
    tick();
    $display("misaligned sw addr=00000402 ades=%b", ades);

    // non-memory op
    issue(6'b000000, 32'h0, 32'h0);
    check("nop_req", mem_req, 0);
    check("nop_done", done, 1);
    check("nop_ades", ades, 0);
    check("nop_adel", adel, 0);
    tick();
    $display("non-memory op done");

    // start during ACCESS ignored, then reset mid-access
    issue(6'b100011, 32'h600, 32'h0);
    start = 1'b1; op = 6'b101000; addr = 32'h700;
    tick();
    start = 1'b0;
    check("busy_ldop", ld_op, 6'b100011);
    check("busy_we", mem_we, 0);
    check("busy_req", mem_req, 1);
    resetn = 1'b0;
    #1;
    check("abort_req", mem_req, 0);
    check("abort_busy", busy, 0);
    tick();
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("abort_nodone", done, 0);
      tick();
    end
    $display("access aborted by reset");

    // lwr after reset release
    issue(6'b100110, 32'h505, 32'hCAFEBABE);
    check("lwr_req", mem_req, 1);
    mem_ack = 1'b1;
    mem_rdata = 32'h01020304;
    tick();
    mem_ack = 1'b0;
    check("lwr_done", done, 1);
    check("lwr_ea", ld_ea, 2'b01);
    check("lwr_rt", ld_rt, 32'hCAFEBABE);
    check("lwr_word", ld_word, 32'h01020304);
    check("lwr_op", ld_op, 6'b100110);
    tick();
    $display("load lwr addr=00000505 word=%h rt=%h", ld_word, ld_rt);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
